// File: rtl/base_processor_pkg.sv
// Shared datapath types and constants for the base processor.
package base_processor_pkg;

  localparam int unsigned WORD_WIDTH = 16;

  typedef logic [WORD_WIDTH-1:0] word_t;

  localparam word_t WORD_RESET = '0;

endpackage : base_processor_pkg

// File: rtl/register.sv
// General-purpose load-enabled storage register fed from the shared datapath bus.
// Optional feature macro: REGISTER_PARITY_EN adds a registered even-parity bit r_parity.
module register #(
  parameter int unsigned       WIDTH       = 16,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rin,
  input  logic [WIDTH-1:0] buswires,
  output logic [WIDTH-1:0] r
`ifdef REGISTER_PARITY_EN
  ,
  output logic             r_parity
`endif
);

  // Capture the bus on rin, hold otherwise; reset dominates asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r        <= RESET_VALUE;
`ifdef REGISTER_PARITY_EN
      r_parity <= ^RESET_VALUE;
`endif
    end else if (rin) begin
      r        <= buswires;
`ifdef REGISTER_PARITY_EN
      r_parity <= ^buswires;
`endif
    end
  end

`ifndef SYNTHESIS
  // Contents must not move when the load enable is low.
  a_hold : assert property (@(posedge clock) disable iff (reset)
    !rin |=> (r === $past(r)));

  // A load takes exactly the word present on the bus at the enabling edge.
  a_load : assert property (@(posedge clock) disable iff (reset)
    rin |=> (r === $past(buswires)));

  // While reset is held the register shows its reset value.
  a_reset_value : assert property (@(posedge clock)
    reset |-> (r === RESET_VALUE));

`ifdef REGISTER_PARITY_EN
  // Stored parity always agrees with the stored word.
  a_parity : assert property (@(posedge clock) disable iff (reset)
    r_parity === ^r);
`endif
`endif

endmodule : register

// File: tb/tb_register.sv
// Self-checking bench for register: directed scenario followed by randomized load/hold/reset traffic.
module tb_register;
  import base_processor_pkg::*;

  logic  clock;
  logic  reset;
  logic  rin;
  word_t buswires;
  word_t r;
`ifdef REGISTER_PARITY_EN
  logic  r_parity;
`endif

  int checks = 0;
  int errors = 0;

  // Reference: the word the register should hold right now.
  word_t exp_r;

  register #(
    .WIDTH      (WORD_WIDTH),
    .RESET_VALUE(WORD_RESET)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .rin     (rin),
    .buswires(buswires),
    .r       (r)
`ifdef REGISTER_PARITY_EN
    ,
    .r_parity(r_parity)
`endif
  );

  // 20 ns clock, rising edges at 10, 30, 50, ...
  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  task automatic check(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Parity of the expected word computed by counting ones.
  function automatic logic exp_parity(input word_t w);
    return logic'($countones(w) % 2);
  endfunction

  task automatic check_parity(input string tag);
`ifdef REGISTER_PARITY_EN
    check(tag, word_t'(r_parity), word_t'(exp_parity(exp_r)));
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit do_rst;

    // t=0: reset asserted, no load requested.
    reset = 1'b1; rin = 1'b0; buswires = 16'h0000;
    exp_r = WORD_RESET;
    #1;  check("reset_immediate", r, 16'h0000);
    check_parity("reset_parity");

    #19; reset = 1'b0;                         // t=20
    #20; rin = 1'b1; buswires = 16'h0000;      // t=40
    #11; check("load_zero", r, 16'h0000);      // t=51

    #29; buswires = 16'hABCD;                  // t=80
    #11; exp_r = 16'hABCD;                     // t=91
    check("load_abcd", r, 16'hABCD);
    check_parity("parity_abcd");

    #29; rin = 1'b0;                           // t=120
    #40; buswires = 16'h000F;                  // t=160
    #11; check("hold_171", r, 16'hABCD);       // t=171
    #20; check("hold_191", r, 16'hABCD);       // t=191

    #9;  rin = 1'b1;                           // t=200
    #11; exp_r = 16'h000F;                     // t=211
    check("reload_000f", r, 16'h000F);
    check_parity("parity_000f");

    // Async reset between edges while a load is pending.
    buswires = 16'h1234;
    #9;  reset = 1'b1;                         // t=220
    #1;  exp_r = WORD_RESET;                   // t=221
    check("async_reset_now", r, WORD_RESET);
    check_parity("async_reset_parity");
    #10; check("reset_over_edge", r, WORD_RESET); // t=231
    #9;  reset = 1'b0;                         // t=240
    #11; exp_r = 16'h1234;                     // t=251
    check("load_after_release", r, 16'h1234);

    // Randomized traffic: inputs change on the falling edge, results checked just after rising edges.
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      do_rst   = ($urandom_range(0, 15) == 0);
      reset    = do_rst;
      rin      = 1'($urandom_range(0, 1));
      buswires = word_t'($urandom);
      #1;
      if (do_rst) begin
        exp_r = WORD_RESET;
        check("rand_async_reset", r, exp_r);
      end
      @(posedge clock);
      if (!reset && rin) exp_r = buswires;
      #1;
      check("rand_after_edge", r, exp_r);
      check_parity("rand_parity");
      // Bus activity between edges must not leak through.
      #4; buswires = word_t'($urandom);
      #2; check("rand_no_transparency", r, exp_r);
    end

    reset = 1'b0; rin = 1'b0;
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_register
